grad_step_engine: RTL

//  Parametrised gradient-descent step for one weight: teta_out = teta_in - epsilon*mean(x_i*(h_i-y_i)).

---
 rtl/grad_pkg.sv | 28 ++
 rtl/grad_mac_lane.sv | 21 ++
 rtl/grad_step_engine.sv | 137 +++++++++++++
 3 files changed

// File: rtl/grad_pkg.sv
// Shared types and helpers for the gradient-descent step engine:
// FSM state encoding, accumulator width rule and signed saturation.
package grad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    SCALE,
    DONE
  } state_t;

  // Sum of up to 2^n_bit products of (DW) x (DW+1) signed operands cannot overflow.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n_bit);
    return 2 * dw + 1 + n_bit;
  endfunction

  function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                 input int unsigned        dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/grad_mac_lane.sv
// Combinational subtract-multiply lane: x * (h - y) with the error kept at
// DW+1 bits so that h - y never wraps.
module grad_mac_lane #(
  parameter int unsigned DW = 8
) (
  input  logic signed [DW-1:0] i_x,
  input  logic signed [DW-1:0] i_h,
  input  logic signed [DW-1:0] i_y,
  output logic signed [2*DW:0] o_prod
);

  logic signed [DW:0]   w_e;
  logic signed [2*DW:0] w_xs;
  logic signed [2*DW:0] w_es;

  assign w_e    = {i_h[DW-1], i_h} - {i_y[DW-1], i_y};
  assign w_xs   = {{(DW+1){i_x[DW-1]}}, i_x};
  assign w_es   = {{DW{w_e[DW]}}, w_e};
  assign o_prod = w_xs * w_es;

endmodule

// File: rtl/grad_step_engine.sv
// One-weight gradient-descent step: teta_out = teta_in - eps * mean(x*(h-y)).
// Define GRAD_SAT_EN to saturate the result; otherwise it wraps to DW bits.
module grad_step_engine
  import grad_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned N        = 8,
  parameter int unsigned N_BIT    = 3,
  parameter int unsigned EPS_FRAC = DW
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BIT:0]    n_used,
  input  logic [N*DW-1:0]   x_col,
  input  logic [N*DW-1:0]   h,
  input  logic [N*DW-1:0]   y,
  input  logic [DW-1:0]     teta_in,
  input  logic [DW-1:0]     epsilon,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     teta_out,
  output logic              busy
);

  localparam int unsigned ACC_W = acc_width(DW, N_BIT);
  localparam int unsigned PW    = ACC_W + DW + 1;
  localparam int unsigned RW    = PW + 1;

  state_t r_state, w_next;

  logic [N*DW-1:0]         r_x, r_h, r_y;
  logic signed [DW-1:0]    r_teta_in;
  logic [DW-1:0]           r_eps;
  logic [N_BIT:0]          r_n_eff;
  logic [N_BIT-1:0]        r_idx;
  logic signed [ACC_W-1:0] r_acc;
  logic [DW-1:0]           r_teta_out;

  logic [N_BIT:0]          w_n_eff;
  logic                    w_last;
  logic signed [DW-1:0]    w_x, w_h, w_y;
  logic signed [2*DW:0]    w_prod;
  logic signed [ACC_W-1:0] w_grad;
  logic signed [PW-1:0]    w_grad_ext, w_eps_ext, w_scaled, w_step;
  logic signed [RW-1:0]    w_result;
  logic [DW-1:0]           w_teta_next;

  assign w_n_eff = (n_used > (N_BIT+1)'(N)) ? (N_BIT+1)'(N) : n_used;
  assign w_last  = ({1'b0, r_idx} == (r_n_eff - (N_BIT+1)'(1)));

  assign w_x = r_x[r_idx*DW +: DW];
  assign w_h = r_h[r_idx*DW +: DW];
  assign w_y = r_y[r_idx*DW +: DW];

  grad_mac_lane #(.DW(DW)) u_mac (
    .i_x   (w_x),
    .i_h   (w_h),
    .i_y   (w_y),
    .o_prod(w_prod)
  );

  // Mean always divides by nominal N, even when fewer samples were used.
  assign w_grad     = r_acc >>> N_BIT;
  assign w_grad_ext = PW'(w_grad);
  assign w_eps_ext  = PW'(r_eps);
  assign w_scaled   = w_grad_ext * w_eps_ext;
  assign w_step     = w_scaled >>> EPS_FRAC;
  assign w_result   = RW'(r_teta_in) - RW'(w_step);

`ifdef GRAD_SAT_EN
  assign w_teta_next = DW'(sat_to(64'(w_result), DW));
`else
  assign w_teta_next = DW'(w_result);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = (r_state == IDLE);
    busy      = (r_state != IDLE);
    out_valid = (r_state == DONE);
    if (enable) begin
      case (r_state)
        IDLE:    if (in_valid) w_next = (w_n_eff == '0) ? SCALE : ACC;
        ACC:     if (w_last) w_next = SCALE;
        SCALE:   w_next = DONE;
        DONE:    if (out_ready) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x        <= '0;
      r_h        <= '0;
      r_y        <= '0;
      r_teta_in  <= '0;
      r_eps      <= '0;
      r_n_eff    <= '0;
      r_idx      <= '0;
      r_acc      <= '0;
      r_teta_out <= '0;
    end else if (enable) begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x       <= x_col;
            r_h       <= h;
            r_y       <= y;
            r_teta_in <= teta_in;
            r_eps     <= epsilon;
            r_n_eff   <= w_n_eff;
            r_idx     <= '0;
            r_acc     <= '0;
          end
        end
        ACC: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          r_idx <= r_idx + 1'b1;
        end
        SCALE:   r_teta_out <= w_teta_next;
        default: ;
      endcase
    end
  end

  assign teta_out = r_teta_out;

endmodule
